// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline register stage: the occupancy state
// encoding and the default payload/control widths.
package pipe_pkg;

  // Occupancy of the stage; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 4;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// pipe_slot
// One storage slot of the pipeline stage: payload, control field and a
// valid bit. The control field is forced to zero whenever the slot is
// loaded with a bubble or cleared, so downstream never sees stale
// write-enables.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   clear       synchronous squash (flush); wins over load
//   load        capture d_valid/d_data/d_ctrl this edge
//   d_valid     valid bit to load (0 loads a bubble)
//   d_data      payload to load
//   d_ctrl      control bits to load
//   q_valid     slot holds an entry
//   q_data      held payload
//   q_ctrl      held control bits (zero when q_valid=0)
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Next-state of the slot: clear beats load, load beats hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = {DATA_W{1'b0}};
      ctrl_d  = {CTRL_W{1'b0}};
    end else if (load) begin
      valid_d = d_valid;
      data_d  = d_data;
      // A bubble must carry no write-enables.
      if (d_valid) begin
        ctrl_d = d_ctrl;
      end else begin
        ctrl_d = {CTRL_W{1'b0}};
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
    end
  end

  // Slot storage with synchronous reset to an empty, all-zero slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      ctrl_q  <= {CTRL_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_ctrl  = ctrl_q;

endmodule : pipe_slot

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid
// Valid/ready pipeline register with optional skid slot.
//   SKID=0: single entry, in_ready = out_ready || !out_valid (combinational).
//   SKID=1: main + skid slots, in_ready comes from a flop so out_ready never
//           reaches in_ready combinationally.
// Outputs always come straight from the main slot, so an accepted entry is
// visible one cycle later and stays stable while stalled.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   flush       squash all held entries next edge (input discarded)
//   in_valid/in_data/in_ctrl/in_ready     upstream handshake
//   out_valid/out_data/out_ctrl/out_ready downstream handshake
//   count       number of held entries (0..2)
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  output logic [1:0]        count
);

  pipe_state_e       state_q, state_d;
  logic              in_xfer, out_xfer;
  logic              main_load, main_from_skid, main_d_valid;
  logic              skid_load, skid_d_valid;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  // Occupancy FSM: picks next state and which slot loads what.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_d_valid   = 1'b0;
    skid_load      = 1'b0;
    skid_d_valid   = 1'b0;
    if (flush) begin
      // Slots are cleared directly; nothing loads.
      state_d = EMPTY;
    end else if (SKID != 0) begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d      = ONE;
            main_load    = 1'b1;
            main_d_valid = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            state_d      = ONE;
            main_load    = 1'b1;
            main_d_valid = 1'b1;
          end else if (in_xfer) begin
            state_d      = TWO;
            skid_load    = 1'b1;
            skid_d_valid = 1'b1;
          end else if (out_xfer) begin
            state_d      = EMPTY;
            main_load    = 1'b1;
            main_d_valid = 1'b0;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            main_d_valid   = 1'b1;
            skid_load      = 1'b1;
            skid_d_valid   = 1'b0;
          end else begin
            state_d = TWO;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end else begin
      case (state_q)
        EMPTY, ONE: begin
          // Input wins: simultaneous in/out replaces the entry.
          if (in_xfer) begin
            state_d      = ONE;
            main_load    = 1'b1;
            main_d_valid = 1'b1;
          end else if (out_xfer) begin
            state_d      = EMPTY;
            main_load    = 1'b1;
            main_d_valid = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Main slot source: skid when draining TWO, else the input port.
  always_comb begin
    if (main_from_skid) begin
      main_d_data = skid_data;
      main_d_ctrl = skid_ctrl;
    end else begin
      main_d_data = in_data;
      main_d_ctrl = in_ctrl;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (main_load),
    .d_valid (main_d_valid),
    .d_data  (main_d_data),
    .d_ctrl  (main_d_ctrl),
    .q_valid (main_valid),
    .q_data  (main_data),
    .q_ctrl  (main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q, in_ready_d;

    assign in_ready_d = (state_d != TWO);

    // Registered ready; resets to 1 because the stage resets to EMPTY.
    always_ff @(posedge clk) begin
      if (reset) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= in_ready_d;
      end
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (skid_load),
      .d_valid (skid_d_valid),
      .d_data  (in_data),
      .d_ctrl  (in_ctrl),
      .q_valid (skid_valid),
      .q_data  (skid_data),
      .q_ctrl  (skid_ctrl)
    );

    // Masked by reset so nothing is offered acceptance while in reset.
    assign in_ready = in_ready_q & ~reset;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_data  = {DATA_W{1'b0}};
    assign skid_ctrl  = {CTRL_W{1'b0}};
    assign in_ready   = ~reset & (out_ready | ~main_valid);
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign count     = state_q;

endmodule : pipe_reg_skid

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload carried through the stage, which covers ALU result, store data and instruction.
REQ-002 Parameter CTRL_W, default 4: width of the control field, which holds write-enable and data-input select bits and is zeroed on bubble or flush.
REQ-003 Parameter SKID, default 1: 0 selects a single-entry stage with combinational ready; 1 selects a two-entry skid stage with registered ready.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous squash of every held entry.
REQ-008 in_valid  input  1  upstream offers in_data/in_ctrl.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 in_ready  output  1  stage accepts this cycle.
REQ-012 out_valid  output  1  stage presents an entry.
REQ-013 out_data  output  DATA_W  head payload.
REQ-014 out_ctrl  output  CTRL_W  head control bits, all-zero whenever out_valid=0.
REQ-015 out_ready  input  1  downstream accepts this cycle.
REQ-016 count  output  2  number of held entries (0..2).

Function
REQ-017 The stage SHALL perform an input transfer exactly when in_valid&&in_ready and an output transfer exactly when out_valid&&out_ready, both sampled at the rising edge of clk.
REQ-018 The stage SHALL deliver entries in acceptance order, with no loss and no duplication.
REQ-019 The stage SHALL have one-cycle latency: an entry accepted at edge N is visible on the outputs after edge N.
REQ-020 For SKID=0, the stage SHALL drive in_ready = out_ready || !out_valid; simultaneous input and output transfers replace the entry; count ranges 0..1.
REQ-021 For SKID=1, the stage SHALL drive in_ready from a register equal to (state != TWO), with no combinational path from out_ready.
REQ-022 For SKID=1, the states SHALL be EMPTY, ONE (main slot holds the entry) and TWO (main and skid slots both hold entries).
REQ-023 From EMPTY, an input transfer SHALL move the stage to ONE; otherwise it stays in EMPTY.
REQ-024 From ONE, the stage SHALL move as follows: input and output transfer together -> ONE with main loaded from the input; input transfer only -> TWO with skid loaded; output transfer only -> EMPTY.
REQ-025 From TWO, an output transfer SHALL move the stage to ONE with main loaded from skid; otherwise it stays in TWO; in_ready=0 throughout.
REQ-026 The stage SHALL hold out_data and out_ctrl stable while out_valid=1 and out_ready=0.
REQ-027 Flush SHALL force state EMPTY, count=0, out_valid=0 and every ctrl register to 0 at the next edge; input offered in the flush cycle is discarded.
REQ-028 Flush SHALL take priority over any simultaneous transfer.
REQ-029 The stage SHALL drive count = 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-030 Reset SHALL take priority over flush and over all transfers.
REQ-031 After reset: state EMPTY, out_valid=0, out_data=0, out_ctrl=0, skid registers=0, count=0.
REQ-032 After reset, in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-operation SHALL drop all held entries without emitting them.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default-width constants PIPE_DATA_W=32 and PIPE_CTRL_W=4.
REQ-035 One sub-module, pipe_slot, SHALL implement a load-enabled, clearable DATA_W+CTRL_W register plus its valid bit; it is instantiated as main and skid, with skid generated only when SKID=1.

Verification
REQ-036 Reset: assert reset with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0, count=0; in_ready=1 one cycle after release.
REQ-037 Streaming, SKID=1: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> outputs 0x1,0x2,0x3 on the next three cycles, count stays 1.
REQ-038 Backpressure, SKID=1: out_ready=0, push 0xA then 0xB -> count=2, in_ready=0, 0xC stalls; raise out_ready -> outputs 0xA,0xB,0xC in order.
REQ-039 Flush in TWO with in_valid=1, in_ctrl=0xF -> next cycle out_valid=0, out_ctrl=0, count=0; 0xF never appears.
REQ-040 SKID=0: out_valid=1, out_ready=0 -> in_ready=0; raise out_ready in the same cycle as in_valid -> entry replaced, count stays 1.
